univ_reg: RTL and testbench

- Parametrised multi-mode register, the successor to the single-bit D flip-flop.
- Holds a WIDTH-bit word and, each clock, can hold, load, shift, rotate, increment or decrement it.
- Reports the bit shifted out, a wrap pulse and a zero flag.
- Serves as the general-purpose storage/counter element in datapaths and test structures.

---
 rtl/univ_reg_pkg.sv | 18 +
 rtl/univ_reg_next.sv | 59 +++++
 rtl/univ_reg.sv | 77 +++++++
 tb/tb_univ_reg.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/univ_reg_pkg.sv
// Shared constants for the multi-mode register: operation encodings and widths.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: MODE_W, MODE_* operation encodings used on the mode port.
package univ_reg_pkg;

   localparam int MODE_W = 3;

   localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
   localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
   localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
   localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
   localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
   localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
   localparam logic [MODE_W-1:0] MODE_INC  = 3'b110;
   localparam logic [MODE_W-1:0] MODE_DEC  = 3'b111;

endpackage

// File: rtl/univ_reg_next.sv
// Next-state logic for univ_reg: computes word, shifted-out bit and wrap flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluates every cycle.
// Ports: q (current word), mode, d (load data), sin (serial in)
//        -> next_q, next_sout, next_wrap.
module univ_reg_next
   import univ_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]  q,
   input  logic [MODE_W-1:0] mode,
   input  logic [WIDTH-1:0]  d,
   input  logic              sin,
   output logic [WIDTH-1:0]  next_q,
   output logic              next_sout,
   output logic              next_wrap
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   // d and sin are referenced only in the arms that select them, so an
   // unknown value on an unselected input never reaches next_q.
   always_comb begin
      next_q    = q;
      next_sout = 1'b0;
      next_wrap = 1'b0;
      case (mode)
         MODE_HOLD: next_q = q;
         MODE_LOAD: next_q = d;
         MODE_SHL: begin
            next_q    = {q[WIDTH-2:0], sin};
            next_sout = q[WIDTH-1];
         end
         MODE_SHR: begin
            next_q    = {sin, q[WIDTH-1:1]};
            next_sout = q[0];
         end
         MODE_ROL: begin
            next_q    = {q[WIDTH-2:0], q[WIDTH-1]};
            next_sout = q[WIDTH-1];
         end
         MODE_ROR: begin
            next_q    = {q[0], q[WIDTH-1:1]};
            next_sout = q[0];
         end
         MODE_INC: begin
            next_q    = q + ONE;
            next_wrap = &q;
         end
         MODE_DEC: begin
            next_q    = q - ONE;
            next_wrap = ~|q;
         end
         default: next_q = q;
      endcase
   end

endmodule

// File: rtl/univ_reg.sv
// Multi-mode register: hold/load/shift/rotate/inc/dec a WIDTH-bit word.
// Latency: q/sout/wrap update one clock edge after inputs; zero is combinational on q.
// Backpressure: none; a new operation is accepted on every edge.
// Ports: clk, rst (async, active-high), clr (sync clear, beats en), en, mode, d, sin
//        -> q, sout, wrap (registered), zero (q == 0).
module univ_reg
   import univ_reg_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [MODE_W-1:0] mode,
   input  logic [WIDTH-1:0]  d,
   input  logic              sin,
   output logic [WIDTH-1:0]  q,
   output logic              sout,
   output logic              wrap,
   output logic              zero
);

   logic [WIDTH-1:0] q_q, q_d;
   logic             sout_q, sout_d;
   logic             wrap_q, wrap_d;

   logic [WIDTH-1:0] next_q;
   logic             next_sout;
   logic             next_wrap;

   univ_reg_next #(
      .WIDTH (WIDTH)
   ) u_next (
      .q         (q_q),
      .mode      (mode),
      .d         (d),
      .sin       (sin),
      .next_q    (next_q),
      .next_sout (next_sout),
      .next_wrap (next_wrap)
   );

   // clr outranks en; sout/wrap are pulses, so they drop whenever no
   // enabled operation is taking place.
   always_comb begin
      q_d    = q_q;
      sout_d = 1'b0;
      wrap_d = 1'b0;
      if (clr) begin
         q_d = RESET_VAL;
      end else if (en) begin
         q_d    = next_q;
         sout_d = next_sout;
         wrap_d = next_wrap;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q    <= RESET_VAL;
         sout_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         sout_q <= sout_d;
         wrap_q <= wrap_d;
      end
   end

   assign q    = q_q;
   assign sout = sout_q;
   assign wrap = wrap_q;
   assign zero = (q_q == '0);

endmodule

// File: tb/tb_univ_reg.sv
// Self-checking bench for univ_reg (WIDTH=8, RESET_VAL=0).
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_univ_reg;
   import univ_reg_pkg::*;

   typedef struct packed {
      logic [7:0] q;
      logic       sout;
      logic       wrap;
      logic       zero;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr = 1'b0;
   logic       en = 1'b0;
   logic [2:0] mode = 3'b000;
   logic [7:0] d = 8'h00;
   logic       sin = 1'b0;
   logic [7:0] q;
   logic       sout, wrap, zero;

   int   n_run = 0;
   int   n_fail = 0;
   exp_t sb[$];
   exp_t got;
   logic [7:0] m_q = 8'h00;

   always #5 clk = ~clk;

   univ_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
      .clk(clk), .rst(rst), .clr(clr), .en(en), .mode(mode), .d(d), .sin(sin),
      .q(q), .sout(sout), .wrap(wrap), .zero(zero)
   );

   // Reference behaviour written directly from the operation table.
   function automatic exp_t model(input logic [7:0] cq, input logic c, input logic e,
                                  input logic [2:0] m, input logic [7:0] dv, input logic s);
      exp_t r;
      r.q = cq; r.sout = 1'b0; r.wrap = 1'b0;
      if (c) r.q = 8'h00;
      else if (e) begin
         case (m)
            3'd1: r.q = dv;
            3'd2: begin r.q = {cq[6:0], s};     r.sout = cq[7]; end
            3'd3: begin r.q = {s, cq[7:1]};     r.sout = cq[0]; end
            3'd4: begin r.q = {cq[6:0], cq[7]}; r.sout = cq[7]; end
            3'd5: begin r.q = {cq[0], cq[7:1]}; r.sout = cq[0]; end
            3'd6: begin r.q = cq + 8'd1; r.wrap = (cq == 8'hFF); end
            3'd7: begin r.q = cq - 8'd1; r.wrap = (cq == 8'h00); end
            default: r.q = cq;
         endcase
      end
      r.zero = (r.q == 8'h00);
      return r;
   endfunction

   // Drive one operation at the falling edge, queue its expected result,
   // and return just after the rising edge that executes it.
   task automatic apply(input logic c, input logic e, input logic [2:0] m,
                        input logic [7:0] dv, input logic s);
      exp_t x;
      @(negedge clk);
      clr = c; en = e; mode = m; d = dv; sin = s;
      x = model(m_q, c, e, m, dv, s);
      m_q = x.q;
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #2;
      n_run++;
      if ({q, sout, wrap, zero} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_initial: got q=%h sout=%b wrap=%b zero=%b, want 00 0 0 1", q, sout, wrap, zero);
      end
      @(negedge clk); rst = 1'b0; m_q = 8'h00;
      apply(1'b0, 1'b1, MODE_LOAD, 8'h5A, 1'b0);
      got = sb.pop_front();
      n_run++;
      if ({q, sout, wrap, zero} !== got) begin
         n_fail++;
         $display("FAIL reset_preload: got q=%h zero=%b, want q=%h zero=%b", q, zero, got.q, got.zero);
      end
      // Raise rst between edges: outputs must clear without a clock edge.
      #2; rst = 1'b1; #1;
      n_run++;
      if ({q, sout, wrap, zero} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_async: got q=%h sout=%b wrap=%b zero=%b, want 00 0 0 1", q, sout, wrap, zero);
      end
      // Held through an edge with an enabled LOAD pending: must stay reset.
      @(negedge clk); en = 1'b1; mode = MODE_LOAD; d = 8'hC3;
      @(posedge clk); #1;
      n_run++;
      if ({q, sout, wrap, zero} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_held: got q=%h sout=%b wrap=%b zero=%b, want 00 0 0 1", q, sout, wrap, zero);
      end
      @(negedge clk); rst = 1'b0; en = 1'b0; m_q = 8'h00;
   endtask

   task automatic test_load_shl;
      logic [2:0] ms [3] = '{MODE_LOAD, MODE_SHL, MODE_SHL};
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 1'b1, ms[i], 8'hA5, 1'b1);
         got = sb.pop_front();
         n_run++;
         if ({q, sout, wrap, zero} !== got) begin
            n_fail++;
            $display("FAIL load_shl step %0d: got q=%h sout=%b wrap=%b, want q=%h sout=%b wrap=%b", i, q, sout, wrap, got.q, got.sout, got.wrap);
         end
         if (i == 1) begin
            n_run++;
            if (q !== 8'h4B || sout !== 1'b1) begin
               n_fail++;
               $display("FAIL shl_first: got q=%h sout=%b, want 4b 1", q, sout);
            end
         end
      end
      n_run++;
      if (q !== 8'h97 || sout !== 1'b0) begin
         n_fail++;
         $display("FAIL shl_second: got q=%h sout=%b, want 97 0", q, sout);
      end
   endtask

   task automatic test_ror;
      apply(1'b0, 1'b1, MODE_LOAD, 8'h01, 1'b0);
      void'(sb.pop_front());
      for (int i = 0; i < 8; i++) begin
         apply(1'b0, 1'b1, MODE_ROR, 8'hFF, 1'b0);
         got = sb.pop_front();
         n_run++;
         if ({q, sout, wrap, zero} !== got) begin
            n_fail++;
            $display("FAIL ror step %0d: got q=%h sout=%b, want q=%h sout=%b", i, q, sout, got.q, got.sout);
         end
         if (i == 0) begin
            n_run++;
            if (q !== 8'h80 || sout !== 1'b1) begin
               n_fail++;
               $display("FAIL ror_first: got q=%h sout=%b, want 80 1", q, sout);
            end
         end
      end
      n_run++;
      if (q !== 8'h01) begin
         n_fail++;
         $display("FAIL ror_full_turn: got q=%h, want 01", q);
      end
   endtask

   task automatic test_inc_wrap;
      logic [2:0] ms [4] = '{MODE_LOAD, MODE_INC, MODE_INC, MODE_HOLD};
      for (int i = 0; i < 4; i++) begin
         apply(1'b0, 1'b1, ms[i], 8'hFE, 1'b0);
         got = sb.pop_front();
         n_run++;
         if ({q, sout, wrap, zero} !== got) begin
            n_fail++;
            $display("FAIL inc step %0d: got q=%h wrap=%b zero=%b, want q=%h wrap=%b zero=%b", i, q, wrap, zero, got.q, got.wrap, got.zero);
         end
         if (i == 2) begin
            n_run++;
            if (q !== 8'h00 || wrap !== 1'b1 || zero !== 1'b1) begin
               n_fail++;
               $display("FAIL inc_wrap: got q=%h wrap=%b zero=%b, want 00 1 1", q, wrap, zero);
            end
         end
      end
      n_run++;
      if (wrap !== 1'b0) begin
         n_fail++;
         $display("FAIL inc_wrap_pulse: got wrap=%b one cycle later, want 0", wrap);
      end
   endtask

   task automatic test_dec_en;
      apply(1'b0, 1'b1, MODE_LOAD, 8'h00, 1'b0);
      void'(sb.pop_front());
      for (int i = 0; i < 4; i++) begin
         apply(1'b0, (i == 0), MODE_DEC, 8'h00, 1'b0);
         got = sb.pop_front();
         n_run++;
         if ({q, sout, wrap, zero} !== got) begin
            n_fail++;
            $display("FAIL dec_en step %0d: got q=%h wrap=%b, want q=%h wrap=%b", i, q, wrap, got.q, got.wrap);
         end
         if (i == 0) begin
            n_run++;
            if (q !== 8'hFF || wrap !== 1'b1) begin
               n_fail++;
               $display("FAIL dec_wrap: got q=%h wrap=%b, want ff 1", q, wrap);
            end
         end
      end
      n_run++;
      if (q !== 8'hFF || wrap !== 1'b0) begin
         n_fail++;
         $display("FAIL en_gate: got q=%h wrap=%b, want ff 0", q, wrap);
      end
   endtask

   task automatic test_clr_priority;
      apply(1'b0, 1'b1, MODE_LOAD, 8'h33, 1'b0);
      void'(sb.pop_front());
      apply(1'b1, 1'b1, MODE_LOAD, 8'h77, 1'b0);
      got = sb.pop_front();
      n_run++;
      if ({q, sout, wrap, zero} !== got || q !== 8'h00) begin
         n_fail++;
         $display("FAIL clr_priority: got q=%h sout=%b wrap=%b, want q=%h 0 0", q, sout, wrap, got.q);
      end
   endtask

   task automatic test_reset_mid;
      logic [7:0] ld [2] = '{8'hFF, 8'h80};
      logic [2:0] op [2] = '{MODE_INC, MODE_SHL};
      for (int i = 0; i < 2; i++) begin
         apply(1'b0, 1'b1, MODE_LOAD, ld[i], 1'b0);
         void'(sb.pop_front());
         apply(1'b0, 1'b1, op[i], 8'h00, 1'b0);
         got = sb.pop_front();
         n_run++;
         if ({q, sout, wrap, zero} !== got) begin
            n_fail++;
            $display("FAIL reset_mid_pre %0d: got q=%h sout=%b wrap=%b, want q=%h sout=%b wrap=%b", i, q, sout, wrap, got.q, got.sout, got.wrap);
         end
         #2; rst = 1'b1; #1;
         n_run++;
         if ({q, sout, wrap, zero} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid %0d: got q=%h sout=%b wrap=%b zero=%b, want 00 0 0 1", i, q, sout, wrap, zero);
         end
         @(negedge clk); rst = 1'b0; m_q = 8'h00;
      end
   endtask

   task automatic test_back_to_back;
      logic       c, e, s;
      logic [2:0] m;
      logic [7:0] dv;
      for (int i = 0; i < 60; i++) begin
         c  = ($urandom_range(0, 15) == 0);
         e  = ($urandom_range(0, 7) != 0);
         m  = 3'($urandom_range(0, 7));
         dv = (m == MODE_LOAD) ? 8'($urandom_range(0, 255)) : 8'hxx;
         s  = (m == MODE_SHL || m == MODE_SHR) ? 1'($urandom_range(0, 1)) : 1'bx;
         apply(c, e, m, dv, s);
         got = sb.pop_front();
         n_run++;
         if ({q, sout, wrap, zero} !== got) begin
            n_fail++;
            $display("FAIL b2b step %0d mode=%0d: got q=%h sout=%b wrap=%b zero=%b, want %h %b %b %b", i, m, q, sout, wrap, zero, got.q, got.sout, got.wrap, got.zero);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_shl();
      test_ror();
      test_inc_wrap();
      test_dec_en();
      test_clr_priority();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
